// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and helpers for the DMEM port arbiter.
// Covers the read-owner tag and safe address-width math.
package dmem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      e_owner_none = 2'd0,
      e_owner_core = 2'd1,
      e_owner_net  = 2'd2
   } dmem_rd_owner_e;

   // A one-word memory still needs a 1-bit address.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dmem_reservation.sv
// LR reservation register. A granted write to the reserved word drops the
// reservation and raises a one-cycle break pulse on the following cycle.
module dmem_reservation #(
   parameter int addr_width_p = 10
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    set_i,
   input  logic [addr_width_p-1:0] set_addr_i,
   input  logic                    wr_v_i,
   input  logic [addr_width_p-1:0] wr_addr_i,
   output logic                    reservation_v_o,
   output logic [addr_width_p-1:0] reservation_addr_o,
   output logic                    break_reserve_o
);

   logic                    res_v_q, res_v_d;
   logic [addr_width_p-1:0] res_addr_q, res_addr_d;
   logic                    break_q, break_d;

   // Set and clear are mutually exclusive: only one grant exists per cycle.
   always_comb begin
      res_v_d    = res_v_q;
      res_addr_d = res_addr_q;
      break_d    = 1'b0;
      if (set_i) begin
         res_v_d    = 1'b1;
         res_addr_d = set_addr_i;
      end else if (wr_v_i && res_v_q && (wr_addr_i == res_addr_q)) begin
         res_v_d = 1'b0;
         break_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         res_v_q    <= 1'b0;
         res_addr_q <= '0;
         break_q    <= 1'b0;
      end else begin
         res_v_q    <= res_v_d;
         res_addr_q <= res_addr_d;
         break_q    <= break_d;
      end
   end

   assign reservation_v_o    = res_v_q;
   assign reservation_addr_o = res_addr_q;
   assign break_reserve_o    = break_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port local DMEM between the core LSU and network requests.
// Issues one grant per cycle, steers read data to its issuer, and owns the LR reservation.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int  data_width_p       = 32,
   parameter int  dmem_size_p        = 1024,
   parameter int  max_core_streak_p  = 4,
   localparam int dmem_addr_width_lp = safe_clog2(dmem_size_p),
   localparam int data_mask_width_lp = data_width_p / 8
) (
   input  logic                          clk_i,
   input  logic                          reset_i,

   input  logic                          core_v_i,
   input  logic                          core_w_i,
   input  logic [dmem_addr_width_lp-1:0] core_addr_i,
   input  logic [data_width_p-1:0]       core_data_i,
   input  logic [data_mask_width_lp-1:0] core_mask_i,
   input  logic                          core_reserve_i,
   output logic                          core_yumi_o,
   output logic                          core_rdata_v_o,
   output logic [data_width_p-1:0]       core_rdata_o,

   input  logic                          net_v_i,
   input  logic                          net_w_i,
   input  logic [dmem_addr_width_lp-1:0] net_addr_i,
   input  logic [data_width_p-1:0]       net_data_i,
   input  logic [data_mask_width_lp-1:0] net_mask_i,
   output logic                          net_yumi_o,
   output logic                          net_rdata_v_o,
   output logic [data_width_p-1:0]       net_rdata_o,

   output logic                          dmem_v_o,
   output logic                          dmem_w_o,
   output logic [dmem_addr_width_lp-1:0] dmem_addr_o,
   output logic [data_width_p-1:0]       dmem_data_o,
   output logic [data_mask_width_lp-1:0] dmem_mask_o,
   input  logic [data_width_p-1:0]       dmem_data_i,

   output logic                          reservation_v_o,
   output logic [dmem_addr_width_lp-1:0] reservation_addr_o,
   output logic                          break_reserve_o
);

   localparam int streak_width_lp = $clog2(max_core_streak_p + 1);
   localparam logic [streak_width_lp-1:0] streak_max_lp = streak_width_lp'(max_core_streak_p);

   typedef struct packed {
      logic                          w;
      logic [dmem_addr_width_lp-1:0] addr;
      logic [data_width_p-1:0]       data;
      logic [data_mask_width_lp-1:0] mask;
   } dmem_req_s;

   dmem_req_s                  core_req, net_req, win_req;
   logic                       core_grant, net_grant;
   logic [streak_width_lp-1:0] streak_q, streak_d;
   dmem_rd_owner_e             rd_owner_q, rd_owner_d;

   // Net wins when the core is idle or has used up its streak allowance.
   always_comb begin
      core_req   = '{w: core_w_i, addr: core_addr_i, data: core_data_i, mask: core_mask_i};
      net_req    = '{w: net_w_i, addr: net_addr_i, data: net_data_i, mask: net_mask_i};
      net_grant  = net_v_i & (~core_v_i | (streak_q == streak_max_lp));
      core_grant = core_v_i & ~net_grant;
      win_req    = net_grant ? net_req : core_req;
   end

   always_comb begin
      streak_d = streak_q;
      if (net_grant || !net_v_i)
         streak_d = '0;
      else if (core_grant && (streak_q != streak_max_lp))
         streak_d = streak_q + streak_width_lp'(1);
   end

   always_comb begin
      rd_owner_d = e_owner_none;
      if (core_grant && !core_w_i)
         rd_owner_d = e_owner_core;
      else if (net_grant && !net_w_i)
         rd_owner_d = e_owner_net;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         streak_q   <= '0;
         rd_owner_q <= e_owner_none;
      end else begin
         streak_q   <= streak_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   assign core_yumi_o    = core_grant;
   assign net_yumi_o     = net_grant;

   assign dmem_v_o       = core_grant | net_grant;
   assign dmem_w_o       = win_req.w;
   assign dmem_addr_o    = win_req.addr;
   assign dmem_data_o    = win_req.data;
   assign dmem_mask_o    = win_req.mask;

   assign core_rdata_v_o = (rd_owner_q == e_owner_core);
   assign net_rdata_v_o  = (rd_owner_q == e_owner_net);
   assign core_rdata_o   = dmem_data_i;
   assign net_rdata_o    = dmem_data_i;

   dmem_reservation #(
      .addr_width_p(dmem_addr_width_lp)
   ) reservation (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .set_i             (core_grant & ~core_w_i & core_reserve_i),
      .set_addr_i        (core_addr_i),
      .wr_v_i            ((core_grant | net_grant) & win_req.w),
      .wr_addr_i         (win_req.addr),
      .reservation_v_o   (reservation_v_o),
      .reservation_addr_o(reservation_addr_o),
      .break_reserve_o   (break_reserve_o)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-masked DMEM model.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_v, core_w, core_reserve;
   logic [9:0]  core_addr;
   logic [31:0] core_data;
   logic [3:0]  core_mask;
   logic        core_yumi, core_rdata_v;
   logic [31:0] core_rdata;
   logic        net_v, net_w;
   logic [9:0]  net_addr;
   logic [31:0] net_data;
   logic [3:0]  net_mask;
   logic        net_yumi, net_rdata_v;
   logic [31:0] net_rdata;
   logic        dmem_v, dmem_w;
   logic [9:0]  dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_mask;
   logic [31:0] dmem_rdata;
   logic        res_v;
   logic [9:0]  res_addr;
   logic        brk;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_v) begin
         if (dmem_w) begin
            for (int b = 0; b < 4; b++)
               if (dmem_mask[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
         end else begin
            dmem_rdata <= mem[dmem_addr];
         end
      end
   end

   dmem_port_arbiter dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .core_v_i          (core_v),
      .core_w_i          (core_w),
      .core_addr_i       (core_addr),
      .core_data_i       (core_data),
      .core_mask_i       (core_mask),
      .core_reserve_i    (core_reserve),
      .core_yumi_o       (core_yumi),
      .core_rdata_v_o    (core_rdata_v),
      .core_rdata_o      (core_rdata),
      .net_v_i           (net_v),
      .net_w_i           (net_w),
      .net_addr_i        (net_addr),
      .net_data_i        (net_data),
      .net_mask_i        (net_mask),
      .net_yumi_o        (net_yumi),
      .net_rdata_v_o     (net_rdata_v),
      .net_rdata_o       (net_rdata),
      .dmem_v_o          (dmem_v),
      .dmem_w_o          (dmem_w),
      .dmem_addr_o       (dmem_addr),
      .dmem_data_o       (dmem_wdata),
      .dmem_mask_o       (dmem_mask),
      .dmem_data_i       (dmem_rdata),
      .reservation_v_o   (res_v),
      .reservation_addr_o(res_addr),
      .break_reserve_o   (brk)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      core_v = 0; core_w = 0; core_reserve = 0; core_addr = '0; core_data = '0; core_mask = '0;
      net_v = 0; net_w = 0; net_addr = '0; net_data = '0; net_mask = '0;
      mem[10'h001] = 32'h1111_1111;
      mem[10'h002] = 32'h2222_2222;
      mem[10'h010] = 32'hDEAD_BEEF;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_core_rdata_v", core_rdata_v, 0);
      chk("rst_net_rdata_v", net_rdata_v, 0);
      chk("rst_res_v", res_v, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_break", brk, 0);
      chk("rst_dmem_v", dmem_v, 0);
      reset = 1'b0;
      tick();

      // core-only read of 0x10
      core_v = 1; core_addr = 10'h010;
      #1;
      chk("rd_core_yumi", core_yumi, 1);
      chk("rd_net_yumi", net_yumi, 0);
      chk("rd_dmem_v", dmem_v, 1);
      chk("rd_dmem_w", dmem_w, 0);
      chk("rd_dmem_addr", dmem_addr, 10'h010);
      tick();
      core_v = 0;
      chk("rd_core_rdata_v", core_rdata_v, 1);
      chk("rd_core_rdata", core_rdata, 32'hDEAD_BEEF);
      chk("rd_net_rdata_v", net_rdata_v, 0);
      tick();
      chk("rd_core_rdata_v_drop", core_rdata_v, 0);

      // both requesting: C,C,C,C,N repeating
      core_v = 1; core_addr = 10'h001;
      net_v = 1; net_addr = 10'h002;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("streak_core_yumi_%0d", i), core_yumi, (i % 5) != 4);
         chk($sformatf("streak_net_yumi_%0d", i), net_yumi, (i % 5) == 4);
         chk($sformatf("streak_addr_%0d", i), dmem_addr, ((i % 5) == 4) ? 10'h002 : 10'h001);
         tick();
         chk($sformatf("streak_core_rv_%0d", i), core_rdata_v, (i % 5) != 4);
         chk($sformatf("streak_net_rv_%0d", i), net_rdata_v, (i % 5) == 4);
      end
      core_v = 0; net_v = 0;
      tick();

      // alternating core/net reads, no bubble
      core_v = 1; core_addr = 10'h001;
      #1;
      chk("alt_core_yumi", core_yumi, 1);
      tick();
      core_v = 0; net_v = 1; net_addr = 10'h002;
      #1;
      chk("alt_core_rv", core_rdata_v, 1);
      chk("alt_core_rdata", core_rdata, 32'h1111_1111);
      chk("alt_net_yumi", net_yumi, 1);
      tick();
      net_v = 0; core_v = 1; core_addr = 10'h002;
      #1;
      chk("alt_net_rv", net_rdata_v, 1);
      chk("alt_net_rdata", net_rdata, 32'h2222_2222);
      chk("alt_core_rv_idle", core_rdata_v, 0);
      chk("alt_core_yumi2", core_yumi, 1);
      tick();
      core_v = 0;
      chk("alt_core_rv2", core_rdata_v, 1);
      chk("alt_core_rdata2", core_rdata, 32'h2222_2222);
      chk("alt_net_rv2", net_rdata_v, 0);
      tick();

      // LR @0x20, net write @0x20 breaks it
      core_v = 1; core_reserve = 1; core_addr = 10'h020;
      #1;
      chk("lr_yumi", core_yumi, 1);
      tick();
      core_v = 0; core_reserve = 0;
      chk("lr_res_v", res_v, 1);
      chk("lr_res_addr", res_addr, 10'h020);
      chk("lr_break_idle", brk, 0);
      net_v = 1; net_w = 1; net_addr = 10'h020; net_data = 32'h0000_00AB; net_mask = 4'b0001;
      #1;
      chk("nw_yumi", net_yumi, 1);
      chk("nw_dmem_w", dmem_w, 1);
      chk("nw_dmem_mask", dmem_mask, 4'b0001);
      chk("nw_dmem_data", dmem_wdata, 32'h0000_00AB);
      tick();
      net_v = 0; net_w = 0;
      chk("nw_res_v", res_v, 0);
      chk("nw_break", brk, 1);
      tick();
      chk("nw_break_once", brk, 0);

      // write to a different word keeps the reservation
      core_v = 1; core_reserve = 1; core_addr = 10'h020;
      tick();
      core_v = 0; core_reserve = 0;
      net_v = 1; net_w = 1; net_addr = 10'h021;
      tick();
      net_v = 0; net_w = 0;
      tick();
      chk("other_res_v", res_v, 1);
      chk("other_break", brk, 0);

      // newer LR replaces the older one
      core_v = 1; core_reserve = 1; core_addr = 10'h030;
      tick();
      core_reserve = 0; core_w = 1; core_addr = 10'h020; core_mask = 4'hF;
      chk("ovr_res_addr", res_addr, 10'h030);
      tick();
      core_v = 0;
      chk("ovr_res_v", res_v, 1);
      chk("ovr_res_addr2", res_addr, 10'h030);
      chk("ovr_break", brk, 0);
      core_v = 1; core_addr = 10'h030;
      tick();
      core_v = 0; core_w = 0;
      chk("cw_res_v", res_v, 0);
      chk("cw_break", brk, 1);
      tick();

      // reset while a net read is in flight
      net_v = 1; net_addr = 10'h002;
      #1;
      chk("rst_rd_yumi", net_yumi, 1);
      tick();
      chk("rst_rd_rv_pre", net_rdata_v, 1);
      #1;
      chk("rst_rd_yumi2", net_yumi, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("rst_rd_rv_async", net_rdata_v, 0);
      tick();
      net_v = 0;
      chk("rst_rd_rv_held", net_rdata_v, 0);
      reset = 1'b0;
      tick();
      chk("rst_rd_rv_after", net_rdata_v, 0);

      // reset clears a built-up streak and a live reservation
      core_v = 1; core_reserve = 1; core_addr = 10'h040;
      net_v = 1; net_addr = 10'h002;
      #1;
      chk("rs_pre_core_yumi", core_yumi, 1);
      tick();
      tick();
      core_reserve = 0;
      chk("rs_pre_res_v", res_v, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("rs_res_v", res_v, 0);
      tick();
      reset = 1'b0;
      for (int j = 0; j < 5; j++) begin
         #1;
         chk($sformatf("rs_core_yumi_%0d", j), core_yumi, j != 4);
         chk($sformatf("rs_net_yumi_%0d", j), net_yumi, j == 4);
         tick();
      end
      core_v = 0; net_v = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
